data_sync_tx_arbiter: RTL and testbench

//   Source-domain scheduler for the Data_Sync CDC path. Arbitrates NUM_REQ requesters

---
 rtl/data_sync_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_data_sync_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_tx_arbiter.sv
// data_sync_tx_arbiter
//   Source-domain scheduler for the Data_Sync CDC path. Arbitrates NUM_REQ requesters
//   round-robin and presents the winning word on UNSYNC_BUS with Bus_Enable high for
//   HOLD_CYCLES, then low for GAP_CYCLES with the word still held. The bus never changes
//   while a transfer is in flight, so the destination can synchronize Bus_Enable and
//   sample the bus safely.
//
// Ports
//   CLK         in   source clock
//   RST         in   asynchronous reset, active-low
//   CTRL_EN     in   1 = new grants allowed; 0 = finish current transfer, then idle
//   REQ         in   per-requester request, held with its data until granted
//   DATA_IN     in   requester i data in bits [i*BUS_WIDTH +: BUS_WIDTH]
//   GNT         out  one-hot single-cycle pulse: word of requester i accepted
//   UNSYNC_BUS  out  word to Data_Sync
//   Bus_Enable  out  enable to Data_Sync, high exactly HOLD_CYCLES per transfer
//   BUSY        out  high whenever a transfer (HOLD or GAP) is in progress
module data_sync_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           CTRL_EN,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   DATA_IN,
  output logic [NUM_REQ-1:0]             GNT,
  output logic [BUS_WIDTH-1:0]           UNSYNC_BUS,
  output logic                           Bus_Enable,
  output logic                           BUSY
);

  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [BUS_WIDTH-1:0]   bus_q, bus_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;

  // Arbitration results
  logic [NUM_REQ-1:0]     prio_mask;
  logic [NUM_REQ-1:0]     req_hi;
  logic [NUM_REQ-1:0]     req_sel;
  logic [NUM_REQ-1:0]     win_oh;
  logic [BUS_WIDTH-1:0]   win_data;
  logic [PtrW-1:0]        ptr_nxt;
  logic                   found;
  logic                   grant;

  // Round-robin pick: requesters at or above ptr take priority; if none of them is
  // requesting, fall back to the lowest requester below ptr (the wrap-around part).
  always_comb begin
    prio_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      prio_mask[i] = (i >= 32'(ptr_q));
    end
    req_hi  = REQ & prio_mask;
    req_sel = (|req_hi) ? req_hi : REQ;

    found    = 1'b0;
    win_oh   = '0;
    win_data = '0;
    ptr_nxt  = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_sel[i] && !found) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_data  = DATA_IN[i*BUS_WIDTH +: BUS_WIDTH];
        ptr_nxt   = (i == NUM_REQ - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. Requests and CTRL_EN are only looked at in IDLE, so a transfer
  // always runs its full HOLD and GAP windows once started.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant   = 1'b0;
    case (state_q)
      StIdle: begin
        if (CTRL_EN && found) begin
          grant   = 1'b1;
          ptr_d   = ptr_nxt;
          cnt_d   = CntW'(HOLD_CYCLES - 1);
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          cnt_d   = CntW'(GAP_CYCLES - 1);
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-values; all outputs come straight from flops.
  always_comb begin
    gnt_d  = '0;
    bus_d  = bus_q;
    en_d   = (state_d == StHold);
    busy_d = (state_d != StIdle);
    if (grant) begin
      gnt_d = win_oh;
      bus_d = win_data;
    end
  end

  assign GNT        = gnt_q;
  assign UNSYNC_BUS = bus_q;
  assign Bus_Enable = en_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Testbench for data_sync_tx_arbiter.
//   dut  : NUM_REQ=2, HOLD=GAP=4, checked by an expected-grant queue and a monitor that
//          also measures Bus_Enable / BUSY window lengths and bus stability.
//   dut1 : NUM_REQ=3, HOLD=GAP=1, checked cycle by cycle against hand-written tables.
module tb_data_sync_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RST1 = 1'b0;
  logic        CTRL_EN = 1'b0;
  logic        CTRL_EN1 = 1'b0;
  logic [1:0]  REQ = '0;
  logic [15:0] DATA_IN = '0;
  logic [1:0]  GNT;
  logic [7:0]  UNSYNC_BUS;
  logic        Bus_Enable;
  logic        BUSY;
  logic [2:0]  REQ1 = '0;
  logic [23:0] DATA_IN1 = '0;
  logic [2:0]  GNT1;
  logic [7:0]  UNSYNC_BUS1;
  logic        Bus_Enable1;
  logic        BUSY1;

  always #5 CLK = ~CLK;

  data_sync_tx_arbiter #(
    .NUM_REQ(2), .BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST), .CTRL_EN(CTRL_EN), .REQ(REQ), .DATA_IN(DATA_IN),
    .GNT(GNT), .UNSYNC_BUS(UNSYNC_BUS), .Bus_Enable(Bus_Enable), .BUSY(BUSY)
  );

  data_sync_tx_arbiter #(
    .NUM_REQ(3), .BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)
  ) dut1 (
    .CLK(CLK), .RST(RST1), .CTRL_EN(CTRL_EN1), .REQ(REQ1), .DATA_IN(DATA_IN1),
    .GNT(GNT1), .UNSYNC_BUS(UNSYNC_BUS1), .Bus_Enable(Bus_Enable1), .BUSY(BUSY1)
  );

  typedef struct {
    logic [1:0]  gnt;
    logic [7:0]  bus;
    int unsigned gap;   // expected cycles since previous grant, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [7:0] b, input int unsigned gap);
    exp_q.push_back('{gnt: g, bus: b, gap: gap});
  endtask

  // ---------------- monitor for dut ----------------
  int unsigned cyc = 0;
  int unsigned last_g = 0;
  int unsigned en_run = 0;
  int unsigned busy_run = 0;
  bit          have_last = 1'b0;
  logic [7:0]  held = '0;
  exp_t        mon_it;

  always @(negedge CLK or negedge RST) begin
    if (!RST) begin
      en_run    = 0;
      busy_run  = 0;
      have_last = 1'b0;
    end else begin
      cyc++;
      if (GNT != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", 32'(GNT), 32'd0);
        end else begin
          mon_it = exp_q.pop_front();
          chk("gnt", 32'(GNT), 32'(mon_it.gnt));
          chk("gnt_bus", 32'(UNSYNC_BUS), 32'(mon_it.bus));
          chk("gnt_with_en", 32'(Bus_Enable), 32'd1);
          if (mon_it.gap != 0 && have_last) chk("gnt_spacing", cyc - last_g, mon_it.gap);
        end
        last_g    = cyc;
        have_last = 1'b1;
      end
      if (Bus_Enable) begin
        en_run++;
      end else if (en_run != 0) begin
        chk("en_len", en_run, 32'd4);
        en_run = 0;
      end
      if (BUSY) begin
        if (busy_run != 0) chk("bus_stable", 32'(UNSYNC_BUS), 32'(held));
        else held = UNSYNC_BUS;
        busy_run++;
      end else if (busy_run != 0) begin
        chk("busy_len", busy_run, 32'd8);
        busy_run = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_gnt(input string name);
    int i = 0;
    while (GNT == '0 && i < 40) begin
      @(negedge CLK);
      i++;
    end
    chk(name, 32'(GNT != '0), 32'd1);
  endtask

  task automatic wait_gnt1(input string name);
    int i = 0;
    while (GNT1 == '0 && i < 40) begin
      @(negedge CLK);
      i++;
    end
    chk(name, 32'(GNT1 != '0), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 80) begin
      @(negedge CLK);
      i++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  localparam logic [2:0] G_TAB [3] = '{3'b010, 3'b100, 3'b001};
  localparam logic [7:0] B_TAB [3] = '{8'h32, 8'h33, 8'h31};

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_gnt", 32'(GNT), 32'd0);
    chk("rst_bus", 32'(UNSYNC_BUS), 32'd0);
    chk("rst_en", 32'(Bus_Enable), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RST  = 1'b1;
    RST1 = 1'b1;
    @(negedge CLK);
    chk("post_rst_gnt", 32'(GNT), 32'd0);
    chk("post_rst_en", 32'(Bus_Enable), 32'd0);

    // 1: single transfer from requester 0
    CTRL_EN = 1'b1;
    DATA_IN = {8'h00, 8'hA5};
    REQ     = 2'b01;
    push(2'b01, 8'hA5, 0);
    wait_gnt("t1_gnt_seen");
    REQ = 2'b00;
    repeat (12) @(negedge CLK);
    chk("t1_idle_busy", 32'(BUSY), 32'd0);
    chk("t1_idle_en", 32'(Bus_Enable), 32'd0);
    chk("t1_idle_bus", 32'(UNSYNC_BUS), 32'hA5);

    // 2: both requesting from a fresh pointer -> alternate, 9 cycles apart
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    RST     = 1'b1;
    DATA_IN = {8'h22, 8'h11};
    push(2'b01, 8'h11, 0);
    push(2'b10, 8'h22, 9);
    push(2'b01, 8'h11, 9);
    push(2'b10, 8'h22, 9);
    REQ = 2'b11;
    wait_drain("t2_drain");
    REQ = 2'b00;
    repeat (12) @(negedge CLK);
    chk("t2_idle_busy", 32'(BUSY), 32'd0);

    // 4: CTRL_EN low blocks grants; dropping it mid-transfer does not abort
    CTRL_EN = 1'b0;
    DATA_IN = {8'h22, 8'h5A};
    REQ     = 2'b01;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      chk("t4_blocked_gnt", 32'(GNT), 32'd0);
      chk("t4_blocked_en", 32'(Bus_Enable), 32'd0);
    end
    CTRL_EN = 1'b1;
    push(2'b01, 8'h5A, 0);
    wait_gnt("t4_gnt_seen");
    @(negedge CLK);
    CTRL_EN = 1'b0;
    chk("t4_still_en", 32'(Bus_Enable), 32'd1);
    repeat (14) @(negedge CLK);
    chk("t4_idle_busy", 32'(BUSY), 32'd0);
    chk("t4_idle_en", 32'(Bus_Enable), 32'd0);
    chk("t4_idle_bus", 32'(UNSYNC_BUS), 32'h5A);

    // 5: reset in the second HOLD cycle; pointer restarts at requester 0
    CTRL_EN = 1'b1;
    DATA_IN = {8'h22, 8'h11};
    push(2'b01, 8'h11, 0);
    wait_gnt("t5_gnt_seen");
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("t5_rst_en", 32'(Bus_Enable), 32'd0);
    chk("t5_rst_gnt", 32'(GNT), 32'd0);
    chk("t5_rst_busy", 32'(BUSY), 32'd0);
    chk("t5_rst_bus", 32'(UNSYNC_BUS), 32'd0);
    REQ = 2'b11;
    @(negedge CLK);
    RST = 1'b1;
    push(2'b01, 8'h11, 0);
    push(2'b10, 8'h22, 9);
    wait_drain("t5_drain");
    REQ = 2'b00;
    repeat (12) @(negedge CLK);
    chk("t5_idle_busy", 32'(BUSY), 32'd0);

    // 6: HOLD=GAP=1, lone requester -> Bus_Enable 1,0,0 and a grant every 3 cycles
    CTRL_EN1 = 1'b1;
    DATA_IN1 = {8'h00, 8'h00, 8'h77};
    REQ1     = 3'b001;
    wait_gnt1("t6_gnt_seen");
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge CLK);
      chk("t6_en", 32'(Bus_Enable1), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk("t6_gnt", 32'(GNT1), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk("t6_bus", 32'(UNSYNC_BUS1), 32'h77);
    end
    REQ1 = 3'b000;
    repeat (4) @(negedge CLK);
    chk("t6_idle_busy", 32'(BUSY1), 32'd0);

    // Three requesters; pointer sits at 1 after the previous grants to requester 0
    DATA_IN1 = {8'h33, 8'h32, 8'h31};
    REQ1     = 3'b111;
    wait_gnt1("t6_rr_gnt_seen");
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge CLK);
      chk("t6_rr_gnt", 32'(GNT1), (k % 3 == 0) ? 32'(G_TAB[k / 3]) : 32'd0);
      chk("t6_rr_bus", 32'(UNSYNC_BUS1), 32'(B_TAB[k / 3]));
      chk("t6_rr_en", 32'(Bus_Enable1), (k % 3 == 0) ? 32'd1 : 32'd0);
    end
    REQ1 = 3'b000;
    repeat (5) @(negedge CLK);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
